// File: rtl/aes_pkg.sv
// aes_pkg: shared types and widths for the SubBytes scheduler
package aes_pkg;
  localparam int AES_DATA_W = 128;
  localparam int AES_WORD_W = 32;
  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESP} sbox_state_e;
  typedef enum logic {OWN_RND, OWN_KEY} sbox_owner_e;
endpackage

// File: rtl/aes_rr_arb2.sv
// aes_rr_arb2: two-way round-robin arbiter, one-hot grant (bit0 = round, bit1 = key)
module aes_rr_arb2
  import aes_pkg::*;
(
  input  logic [1:0]  req_i,
  input  sbox_owner_e last_grant_i,
  output logic [1:0]  grant_o
);
  assign grant_o = (&req_i) ? ((last_grant_i == OWN_KEY) ? 2'b01 : 2'b10) : req_i;
endmodule

// File: rtl/aes_sbox_sched.sv
// aes_sbox_sched: shares one 128-bit SubBytes unit between the round datapath and key expansion
module aes_sbox_sched
  import aes_pkg::*;
#(
  parameter  int DATA_W      = AES_DATA_W,
  parameter  int WORD_W      = AES_WORD_W,
  parameter  int SUB_LATENCY = 2,
  localparam int CNT_W       = $clog2(SUB_LATENCY + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rnd_req_valid,
  output logic              rnd_req_ready,
  input  logic [DATA_W-1:0] rnd_req_data,
  output logic              rnd_rsp_valid,
  input  logic              rnd_rsp_ready,
  output logic [DATA_W-1:0] rnd_rsp_data,
  input  logic              key_req_valid,
  output logic              key_req_ready,
  input  logic [WORD_W-1:0] key_req_word,
  output logic              key_rsp_valid,
  input  logic              key_rsp_ready,
  output logic [WORD_W-1:0] key_rsp_word,
  output logic              sub_en,
  output logic [DATA_W-1:0] sub_data_in,
  input  logic [DATA_W-1:0] sub_data_out,
  output logic              busy
);
  sbox_state_e       state_q, state_d;
  sbox_owner_e       owner_q, owner_d, last_q, last_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] op_q, op_d, res_q, res_d;
  logic [1:0]        grant;
  aes_rr_arb2 u_arb (
    .req_i        ({key_req_valid, rnd_req_valid}),
    .last_grant_i (last_q),
    .grant_o      (grant)
  );
  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    last_d        = last_q;
    cnt_d         = cnt_q;
    op_d          = op_q;
    res_d         = res_q;
    rnd_req_ready = 1'b0;
    key_req_ready = 1'b0;
    rnd_rsp_valid = 1'b0;
    key_rsp_valid = 1'b0;
    sub_en        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        rnd_req_ready = grant[0];
        key_req_ready = grant[1];
        if (|grant) begin
          op_d    = grant[0] ? rnd_req_data : {{(DATA_W-WORD_W){1'b0}}, key_req_word};
          owner_d = grant[0] ? OWN_RND : OWN_KEY;
          last_d  = owner_d;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        sub_en  = 1'b1;
        cnt_d   = CNT_W'(SUB_LATENCY - 1);
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        sub_en  = 1'b1;
        cnt_d   = (cnt_q == '0) ? cnt_q : cnt_q - 1'b1;
        res_d   = (cnt_q == '0) ? sub_data_out : res_q;
        state_d = (cnt_q == '0) ? ST_RESP : ST_WAIT;
      end
      ST_RESP: begin
        rnd_rsp_valid = owner_q == OWN_RND;
        key_rsp_valid = owner_q == OWN_KEY;
        // only the owner's ready can retire the response
        if ((owner_q == OWN_RND) ? rnd_rsp_ready : key_rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      owner_q <= OWN_RND;
      last_q  <= OWN_KEY;
      cnt_q   <= '0;
      op_q    <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      res_q   <= res_d;
    end
  end
  assign sub_data_in  = op_q;
  assign rnd_rsp_data = res_q;
  assign key_rsp_word = res_q[WORD_W-1:0];
  assign busy         = state_q != ST_IDLE;
endmodule

// File: tb/tb_aes_sbox_sched.sv
// tb_aes_sbox_sched: randomized scoreboard bench for the shared SubBytes scheduler
module tb_aes_sbox_sched;
  localparam int L = 2;
  logic clk = 1'b0, rst = 1'b0;
  logic rnd_req_valid = 1'b0, rnd_rsp_ready = 1'b1, key_req_valid = 1'b0, key_rsp_ready = 1'b1;
  logic [127:0] rnd_req_data = '0;
  logic [31:0] key_req_word = '0;
  logic rnd_req_ready, rnd_rsp_valid, key_req_ready, key_rsp_valid, sub_en, busy;
  logic [127:0] rnd_rsp_data, sub_data_in, sub_data_out;
  logic [31:0] key_rsp_word;
  logic [127:0] pipe [L];
  int checks = 0, errors = 0, cyc = 0;
  bit rand_rdy = 1'b0;
  logic [127:0] rnd_q[$];
  logic [31:0] key_q[$];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  aes_sbox_sched #(.SUB_LATENCY(L)) dut (
    .clk(clk), .rst(rst),
    .rnd_req_valid(rnd_req_valid), .rnd_req_ready(rnd_req_ready), .rnd_req_data(rnd_req_data),
    .rnd_rsp_valid(rnd_rsp_valid), .rnd_rsp_ready(rnd_rsp_ready), .rnd_rsp_data(rnd_rsp_data),
    .key_req_valid(key_req_valid), .key_req_ready(key_req_ready), .key_req_word(key_req_word),
    .key_rsp_valid(key_rsp_valid), .key_rsp_ready(key_rsp_ready), .key_rsp_word(key_rsp_word),
    .sub_en(sub_en), .sub_data_in(sub_data_in), .sub_data_out(sub_data_out), .busy(busy)
  );
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = '0;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction
  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    return 8'((b << n) | (b >> (8 - n)));
  endfunction
  // AES S-box from its definition: GF(2^8) inverse (a^254) then the affine map
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] v = 8'h01;
    for (int i = 0; i < 254; i++) v = gmul(v, a);
    return v ^ rotl(v, 1) ^ rotl(v, 2) ^ rotl(v, 3) ^ rotl(v, 4) ^ 8'h63;
  endfunction
  function automatic logic [127:0] sub_bytes(input logic [127:0] x);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[i*8 +: 8] = sbox(x[i*8 +: 8]);
    return r;
  endfunction
  // stand-in for the shared S-box unit: L-stage pipeline, fed only while enabled
  always @(posedge clk) begin
    pipe[0] <= sub_en ? sub_bytes(sub_data_in) : '0;
    for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
  end
  assign sub_data_out = pipe[L-1];
  task automatic chk(input bit ok, input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask
  // monitor and scoreboard
  initial begin
    int last_own = 1, cur_own = 0, exp_own, hs_cyc = 0, en_cnt = 0;
    bit op_active = 0, seen = 0;
    logic [127:0] exp_op = '0, t;
    forever begin
      @(negedge clk);
      if (!rst) begin
        rnd_q.delete();
        key_q.delete();
        op_active = 0;
        last_own = 1;
        continue;
      end
      if (sub_en) begin
        en_cnt++;
        chk(op_active && !seen && sub_data_in == exp_op, "sub_data_in", sub_data_in, exp_op);
      end
      if (busy && (rnd_req_ready || key_req_ready))
        chk(0, "ready_while_busy", {rnd_req_ready, key_req_ready}, 0);
      if ((rnd_req_valid && rnd_req_ready) || (key_req_valid && key_req_ready)) begin
        exp_own = (rnd_req_valid && key_req_valid) ? (last_own == 1 ? 0 : 1) : (rnd_req_valid ? 0 : 1);
        cur_own = rnd_req_ready ? 0 : 1;
        chk(cur_own == exp_own && !(rnd_req_ready && key_req_ready), "grant", cur_own, exp_own);
        last_own = exp_own;
        exp_op = cur_own == 0 ? rnd_req_data : {96'b0, key_req_word};
        t = sub_bytes(exp_op);
        if (cur_own == 0) rnd_q.push_back(t); else key_q.push_back(t[31:0]);
        op_active = 1; seen = 0; hs_cyc = cyc; en_cnt = 0;
      end
      if (rnd_rsp_valid && key_rsp_valid) chk(0, "both_rsp_valid", 1, 0);
      if (rnd_rsp_valid || key_rsp_valid) begin
        if (!op_active || (rnd_rsp_valid ? cur_own != 0 : cur_own != 1) ||
            (rnd_rsp_valid ? rnd_q.size() == 0 : key_q.size() == 0)) begin
          chk(0, "unexpected_rsp", {rnd_rsp_valid, key_rsp_valid}, 0);
        end else begin
          if (!seen) begin
            chk(cyc - hs_cyc == L + 2, "latency", cyc - hs_cyc, L + 2);
            chk(en_cnt == L + 1, "sub_en_cycles", en_cnt, L + 1);
            seen = 1;
          end
          chk(!sub_en, "sub_en_in_resp", sub_en, 0);
          if (rnd_rsp_valid) begin
            chk(rnd_rsp_data == rnd_q[0], "rnd_rsp_data", rnd_rsp_data, rnd_q[0]);
            if (rnd_rsp_ready) begin void'(rnd_q.pop_front()); op_active = 0; end
          end else begin
            chk(key_rsp_word == key_q[0], "key_rsp_word", key_rsp_word, key_q[0]);
            if (key_rsp_ready) begin void'(key_q.pop_front()); op_active = 0; end
          end
        end
      end
    end
  end
  initial forever begin
    @(posedge clk);
    #1;
    if (rand_rdy) {rnd_rsp_ready, key_rsp_ready} = 2'($urandom);
  end
  task automatic send_rnd(input logic [127:0] d);
    bit hs = 0;
    rnd_req_data = d;
    rnd_req_valid = 1'b1;
    for (int n = 0; n < 200 && !hs; n++) begin
      @(negedge clk);
      hs = rnd_req_ready;
      @(posedge clk);
      #1;
    end
    if (!hs) chk(0, "rnd_req_timeout", 0, 1);
    rnd_req_valid = 1'b0;
  endtask
  task automatic send_key(input logic [31:0] w);
    bit hs = 0;
    key_req_word = w;
    key_req_valid = 1'b1;
    for (int n = 0; n < 200 && !hs; n++) begin
      @(negedge clk);
      hs = key_req_ready;
      @(posedge clk);
      #1;
    end
    if (!hs) chk(0, "key_req_timeout", 0, 1);
    key_req_valid = 1'b0;
  endtask
  task automatic drain();
    int n;
    for (n = 0; n < 400; n++) begin
      @(negedge clk);
      if (rnd_q.size() == 0 && key_q.size() == 0 && !busy && !rnd_req_valid && !key_req_valid) break;
    end
    chk(n < 400, "drain", n, 0);
    @(posedge clk);
    #1;
  endtask
  task automatic wait_rsp(input bit key, input logic [127:0] exp);
    bit got = 0;
    for (int n = 0; n < 50 && !got; n++) begin
      @(negedge clk);
      got = key ? key_rsp_valid : rnd_rsp_valid;
    end
    chk(got && (key ? {96'b0, key_rsp_word} == exp : rnd_rsp_data == exp),
        key ? "key_vector" : "rnd_vector", key ? {96'b0, key_rsp_word} : rnd_rsp_data, exp);
  endtask
  initial begin
    logic [127:0] held;
    repeat (2) @(posedge clk);
    #1;
    chk({rnd_req_ready, key_req_ready, rnd_rsp_valid, key_rsp_valid, sub_en, busy} == 0 &&
        sub_data_in == 0 && rnd_rsp_data == 0 && key_rsp_word == 0, "reset_outputs",
        {rnd_req_ready, key_req_ready, rnd_rsp_valid, key_rsp_valid, sub_en, busy}, 0);
    // both requesters valid straight out of reset: grants must alternate starting with round
    fork
      for (int i = 0; i < 4; i++) send_rnd({$urandom, $urandom, $urandom, $urandom});
      for (int i = 0; i < 4; i++) send_key($urandom);
      begin @(posedge clk); #2 rst = 1'b1; end
    join
    drain();
    send_rnd(128'h40bfabf406ee4d3042ca6b997a5c5816);
    wait_rsp(0, 128'h090862bf6f28e3042c747feeda4a6a47);
    drain();
    send_key(32'hcf4f3c09);
    wait_rsp(1, 128'h8a84eb01);
    drain();
    // response backpressure while the other requester waits
    rnd_rsp_ready = 1'b0;
    send_rnd({$urandom, $urandom, $urandom, $urandom});
    fork send_key($urandom); join_none
    wait_rsp(0, rnd_q.size() ? rnd_q[0] : '0);
    held = rnd_rsp_data;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk(rnd_rsp_valid && busy && !key_req_ready && rnd_rsp_data == held, "backpressure",
          {rnd_rsp_valid, busy, key_req_ready}, 3'b110);
    end
    @(posedge clk);
    #1 rnd_rsp_ready = 1'b1;
    drain();
    // reset in the middle of the latency wait drops the operation
    send_rnd({$urandom, $urandom, $urandom, $urandom});
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk({rnd_req_ready, key_req_ready, rnd_rsp_valid, key_rsp_valid, sub_en, busy} == 0 &&
        sub_data_in == 0 && rnd_rsp_data == 0 && key_rsp_word == 0, "async_reset_outputs",
        {rnd_req_ready, key_req_ready, rnd_rsp_valid, key_rsp_valid, sub_en, busy}, 0);
    @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk(!busy, "idle_after_reset", busy, 0);
    send_key($urandom);
    drain();
    // randomized traffic with random response readiness
    rand_rdy = 1'b1;
    fork
      for (int i = 0; i < 12; i++) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1 send_rnd({$urandom, $urandom, $urandom, $urandom});
      end
      for (int i = 0; i < 12; i++) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1 send_key($urandom);
      end
    join
    rand_rdy = 1'b0;
    @(posedge clk);
    #2 {rnd_rsp_ready, key_rsp_ready} = 2'b11;
    drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
